uart_tx_serial: RTL and testbench

UART_TX_SERIAL -- requirements
Module: uart_tx_serial

---
 rtl/uart_tx_serial_pkg.sv | 16 +
 rtl/uart_tx_serial_baud_gen.sv | 29 ++
 rtl/uart_tx_serial.sv | 145 ++++++++++++++
 tb/tb_uart_tx_serial.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_serial_pkg.sv
// Shared definitions for the UART transmitter: state encodings,
// the oversampling ratio and the default baud divisor.
package uart_tx_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int OVERSAMPLE   = 16;
  localparam int DEFAULT_DVSR = 163;

endpackage

// File: rtl/uart_tx_serial_baud_gen.sv
// Free-running baud tick generator: one-cycle s_tick every DVSR clocks
// (counter 0..DVSR-1, tick while the counter sits at DVSR-1).
module baud_gen
  import uart_tx_serial_pkg::*;
#(
  parameter int DVSR = DEFAULT_DVSR
) (
  input  logic CLK,
  input  logic RESET,
  output logic s_tick
);

  localparam int W = (DVSR > 2) ? $clog2(DVSR) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt <= '0;
    end else if (cnt == W'(DVSR - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign s_tick = (cnt == W'(DVSR - 1));

endmodule

// File: rtl/uart_tx_serial.sv
// UART serial transmitter fed from a TX FIFO, 16x oversampled baud ticks.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, pops the FIFO head as soon as it is non-empty
// START  | start bit (low) for 16 ticks
// DATA   | DBIT data bits, LSB first, 16 ticks each
// PARITY | even parity of the latched word, 16 ticks (parity builds only)
// STOP   | line high for SB_TICK ticks
module uart_tx_serial
  import uart_tx_serial_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = DEFAULT_DVSR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FIFO_empty,
  input  logic [DBIT-1:0] data_in,
  output logic            RD_FIFO,
  output logic            TX,
  output logic            BUSY,
  output logic [2:0]      STATE
);

  localparam int TW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int IW = (DBIT > 1) ? $clog2(DBIT) : 1;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [IW-1:0]   bit_idx;
  logic [DBIT-1:0] shift;
  logic [DBIT-1:0] shift_nx;
  logic            tx_q;
  logic            s_tick;
`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif

  baud_gen #(.DVSR(DVSR)) u_baud_gen (
    .CLK    (CLK),
    .RESET  (RESET),
    .s_tick (s_tick)
  );

  // The pop strobe must be dead during reset even though state already reads IDLE.
  assign RD_FIFO  = !RESET && (state == ST_IDLE) && !FIFO_empty;
  assign BUSY     = (state != ST_IDLE);
  assign STATE    = state;
  assign TX       = tx_q;
  assign shift_nx = shift >> 1;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!FIFO_empty) begin
            state    <= ST_START;
            shift    <= data_in;
            tick_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= ^data_in;
`endif
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
              state    <= ST_DATA;
              tick_cnt <= '0;
              tx_q     <= shift[0];
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
              tick_cnt <= '0;
              shift    <= shift_nx;
              if (bit_idx == IW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                state <= ST_PARITY;
                tx_q  <= par_q;
`else
                state <= ST_STOP;
                tx_q  <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + IW'(1);
                tx_q    <= shift_nx[0];
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (s_tick) begin
            if (tick_cnt == TW'(OVERSAMPLE - 1)) begin
              state    <= ST_STOP;
              tick_cnt <= '0;
              tx_q     <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
`endif
        ST_STOP: begin
          tx_q <= 1'b1;
          if (s_tick) begin
            if (tick_cnt == TW'(SB_TICK - 1)) begin
              state    <= ST_IDLE;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          tick_cnt <= '0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serial.sv
// Directed bench for uart_tx_serial at DVSR=2 (one bit = 32 clocks);
// a second instance uses SB_TICK=32. Honours UART_TX_PARITY_EN.
module tb_uart_tx_serial;

`ifdef UART_TX_PARITY_EN
  localparam int NB        = 11;
  localparam int FRAME_CYC = 352;
  localparam logic EXP_31 [0:NB-1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
  localparam int NB        = 10;
  localparam int FRAME_CYC = 320;
  localparam logic EXP_31 [0:NB-1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`endif
  localparam int FRAME2 = FRAME_CYC + 32;
  localparam int LOGN   = 1200;
  localparam logic [7:0] B2B [0:2] = '{8'h37, 8'h30, 8'h0D};
  localparam logic EXP_PAR [0:2] = '{1'b1, 1'b0, 1'b1};

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       rd, tx, busy, rd2, tx2, busy2;
  logic [2:0] state, state2;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_pulses = 0;

  logic       tx_log    [0:LOGN-1];
  logic       busy_log  [0:LOGN-1];
  logic [2:0] st_log    [0:LOGN-1];
  logic       tx2_log   [0:LOGN-1];
  logic       busy2_log [0:LOGN-1];

  uart_tx_serial #(.DBIT(8), .SB_TICK(16), .DVSR(2)) dut (
    .CLK(CLK), .RESET(RESET), .FIFO_empty(fifo_empty), .data_in(data_in),
    .RD_FIFO(rd), .TX(tx), .BUSY(busy), .STATE(state)
  );

  uart_tx_serial #(.DBIT(8), .SB_TICK(32), .DVSR(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .FIFO_empty(fifo_empty), .data_in(data_in),
    .RD_FIFO(rd2), .TX(tx2), .BUSY(busy2), .STATE(state2)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (rd === 1'b1) rd_pulses++;

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; fifo_empty = 1'b1; data_in = 8'h00;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    rd_pulses = 0;
  endtask

  // Present one word so that START begins on the second edge after reset release,
  // then empty the FIFO; returns at the negedge of frame cycle 0.
  task automatic push_aligned(input logic [7:0] b);
    @(posedge CLK); #1;
    data_in = b; fifo_empty = 1'b0;
    @(posedge CLK); #1;
    fifo_empty = 1'b1;
    @(negedge CLK);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[i] = tx; busy_log[i] = busy; st_log[i] = state;
      tx2_log[i] = tx2; busy2_log[i] = busy2;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; fifo_empty = 1'b0; data_in = 8'h55;
    #1;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: actual %0d, required 0", state); end
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: actual %0b, required 1", tx); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: actual %0b, required 0", busy); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: actual %0b, required 0", rd); end
    repeat (2) @(negedge CLK);
    n_checks++; if (state !== 3'd0 || tx !== 1'b1 || rd !== 1'b0) begin
      n_fail++; $display("FAIL reset_held: state %0d tx %0b rd %0b, required 0 1 0", state, tx, rd);
    end
    fifo_empty = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    n_checks++; if (state !== 3'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: state %0d busy %0b, required 0 0", state, busy);
    end
  endtask

  task automatic test_frame_31();
    int errs, bcnt;
    do_reset();
    push_aligned(8'h31);
    capture(FRAME_CYC + 20);
    n_checks++; if (rd_pulses !== 1) begin n_fail++; $display("FAIL frame31_rd_pulses: actual %0d, required 1", rd_pulses); end
    for (int b = 0; b < NB; b++) begin
      errs = 0;
      for (int k = 0; k < 32; k++) if (tx_log[b*32+k] !== EXP_31[b]) errs++;
      n_checks++;
      if (errs != 0) begin n_fail++; $display("FAIL frame31_bit%0d: %0d wrong samples, required 0 (level %0b)", b, errs, EXP_31[b]); end
    end
    bcnt = 0;
    for (int i = 0; i < FRAME_CYC + 20; i++) if (busy_log[i] === 1'b1) bcnt++;
    n_checks++; if (bcnt != FRAME_CYC) begin n_fail++; $display("FAIL frame31_busy_len: actual %0d, required %0d", bcnt, FRAME_CYC); end
    n_checks++; if (busy_log[FRAME_CYC] !== 1'b0 || tx_log[FRAME_CYC] !== 1'b1) begin
      n_fail++; $display("FAIL frame31_end: busy %0b tx %0b, required 0 1", busy_log[FRAME_CYC], tx_log[FRAME_CYC]);
    end
    n_checks++; if (st_log[0] !== 3'd1) begin n_fail++; $display("FAIL frame31_st_start: actual %0d, required 1", st_log[0]); end
    n_checks++; if (st_log[32] !== 3'd2) begin n_fail++; $display("FAIL frame31_st_data: actual %0d, required 2", st_log[32]); end
`ifdef UART_TX_PARITY_EN
    n_checks++; if (st_log[288] !== 3'd3) begin n_fail++; $display("FAIL frame31_st_parity: actual %0d, required 3", st_log[288]); end
`endif
    n_checks++; if (st_log[FRAME_CYC-32] !== 3'd4) begin n_fail++; $display("FAIL frame31_st_stop: actual %0d, required 4", st_log[FRAME_CYC-32]); end
    n_checks++; if (st_log[FRAME_CYC] !== 3'd0) begin n_fail++; $display("FAIL frame31_st_idle: actual %0d, required 0", st_log[FRAME_CYC]); end
  endtask

  task automatic test_idle_empty();
    int bad_tx, bad_st, bad_busy;
    do_reset();
    bad_tx = 0; bad_st = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (tx !== 1'b1) bad_tx++;
      if (state !== 3'd0) bad_st++;
      if (busy !== 1'b0) bad_busy++;
    end
    n_checks++; if (rd_pulses !== 0) begin n_fail++; $display("FAIL idle_rd: actual %0d pulses, required 0", rd_pulses); end
    n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL idle_tx: %0d low cycles, required 0", bad_tx); end
    n_checks++; if (bad_st != 0) begin n_fail++; $display("FAIL idle_state: %0d non-idle cycles, required 0", bad_st); end
    n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy: %0d busy cycles, required 0", bad_busy); end
  endtask

  task automatic test_back_to_back();
    int ptr, nfr, i, first_hi, last_hi, lows, rises;
    logic popped;
    logic [7:0] b;
    do_reset();
    ptr = 0;
    data_in = B2B[0]; fifo_empty = 1'b0;
    @(negedge CLK);
    for (int n = 0; n < LOGN; n++) begin
      tx_log[n] = tx; busy_log[n] = busy;
      popped = rd;
      @(posedge CLK); #1;
      if (popped === 1'b1) ptr++;
      fifo_empty = (ptr >= 3);
      data_in = (ptr < 3) ? B2B[ptr] : 8'h00;
      @(negedge CLK);
    end
    n_checks++; if (rd_pulses !== 3) begin n_fail++; $display("FAIL b2b_rd_pulses: actual %0d, required 3", rd_pulses); end
    nfr = 0; i = 1;
    while (i < LOGN - 400 && nfr < 3) begin
      if (tx_log[i-1] === 1'b1 && tx_log[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = tx_log[i + 16 + 32*(k+1)];
        n_checks++; if (b !== B2B[nfr]) begin n_fail++; $display("FAIL b2b_byte%0d: actual %02h, required %02h", nfr, b, B2B[nfr]); end
`ifdef UART_TX_PARITY_EN
        n_checks++; if (tx_log[i + 16 + 32*9] !== EXP_PAR[nfr]) begin
          n_fail++; $display("FAIL b2b_parity%0d: actual %0b, required %0b", nfr, tx_log[i + 16 + 32*9], EXP_PAR[nfr]);
        end
`endif
        n_checks++; if (tx_log[i + 16 + 32*(NB-1)] !== 1'b1) begin n_fail++; $display("FAIL b2b_stop%0d: actual 0, required 1", nfr); end
        nfr++;
        i = i + 16 + 32*(NB-1);
      end else begin
        i++;
      end
    end
    n_checks++; if (nfr != 3) begin n_fail++; $display("FAIL b2b_frames: actual %0d, required 3", nfr); end
    first_hi = -1; last_hi = -1; rises = 0;
    for (int n = 0; n < LOGN; n++) if (busy_log[n] === 1'b1) begin
      if (first_hi < 0) first_hi = n;
      last_hi = n;
      if (n == 0 || busy_log[n-1] !== 1'b1) rises++;
    end
    lows = 0;
    for (int n = 0; n < LOGN; n++) if (n > first_hi && n < last_hi && busy_log[n] !== 1'b1) lows++;
    n_checks++; if (rises != 3) begin n_fail++; $display("FAIL b2b_busy_rises: actual %0d, required 3", rises); end
    n_checks++; if (lows != 2) begin n_fail++; $display("FAIL b2b_idle_gaps: actual %0d idle cycles, required 2", lows); end
  endtask

  task automatic test_reset_mid_frame();
    int bad_busy, bad_tx;
    do_reset();
    push_aligned(8'hA5);
    repeat (140) @(negedge CLK);
    n_checks++; if (state !== 3'd2 || tx !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pre: state %0d tx %0b, required 2 0", state, tx);
    end
    RESET = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: actual %0b, required 1", tx); end
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL midrst_state: actual %0d, required 0", state); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: actual %0b, required 0", busy); end
    @(posedge CLK); #1 RESET = 1'b0;
    rd_pulses = 0; bad_busy = 0; bad_tx = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (busy !== 1'b0) bad_busy++;
      if (tx !== 1'b1) bad_tx++;
    end
    n_checks++; if (rd_pulses !== 0 || bad_busy != 0 || bad_tx != 0) begin
      n_fail++; $display("FAIL midrst_resend: rd %0d busy %0d txlow %0d, required 0 0 0", rd_pulses, bad_busy, bad_tx);
    end
  endtask

  task automatic test_two_stop();
    int lows, highs, bcnt, bcnt1;
    do_reset();
    push_aligned(8'hFF);
    capture(FRAME2 + 20);
    lows = 0;
    for (int i = 0; i < 32; i++) if (tx2_log[i] === 1'b0) lows++;
    n_checks++; if (lows != 32) begin n_fail++; $display("FAIL sb32_start: %0d low cycles, required 32", lows); end
    highs = 0;
    for (int i = FRAME2 - 64; i < FRAME2; i++) if (tx2_log[i] === 1'b1 && busy2_log[i] === 1'b1) highs++;
    n_checks++; if (highs != 64) begin n_fail++; $display("FAIL sb32_stop_len: %0d high busy cycles, required 64", highs); end
`ifdef UART_TX_PARITY_EN
    lows = 0;
    for (int i = 288; i < 320; i++) if (tx2_log[i] === 1'b0) lows++;
    n_checks++; if (lows != 32) begin n_fail++; $display("FAIL sb32_parity: %0d low cycles, required 32", lows); end
`endif
    bcnt = 0; bcnt1 = 0;
    for (int i = 0; i < FRAME2 + 20; i++) begin
      if (busy2_log[i] === 1'b1) bcnt++;
      if (busy_log[i] === 1'b1) bcnt1++;
    end
    n_checks++; if (bcnt != FRAME2) begin n_fail++; $display("FAIL sb32_busy_len: actual %0d, required %0d", bcnt, FRAME2); end
    n_checks++; if (busy2_log[FRAME2] !== 1'b0 || tx2_log[FRAME2] !== 1'b1) begin
      n_fail++; $display("FAIL sb32_end: busy %0b tx %0b, required 0 1", busy2_log[FRAME2], tx2_log[FRAME2]);
    end
    n_checks++; if (bcnt1 != FRAME_CYC) begin n_fail++; $display("FAIL sb16_ff_busy_len: actual %0d, required %0d", bcnt1, FRAME_CYC); end
  endtask

  initial begin
    test_reset();
    test_frame_31();
    test_idle_empty();
    test_back_to_back();
    test_reset_mid_frame();
    test_two_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
